// File: rtl/alu_operand_stage.sv
// ALU operand pipeline stage: captures decoded instructions, resolves EX/WB hazards and holds operands for the ALU.
// Define ALU_OPERAND_STAGE_FWD_EN to forward EX/WB results; otherwise any in-flight write to a used source stalls.
module alu_operand_stage #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [0:INSTR_W-1]  in_instr,
    input  logic [0:DATA_W-1]   in_rA_data,
    input  logic [0:DATA_W-1]   in_rB_data,
    input  logic                ex_fwd_valid,
    input  logic                ex_pending,
    input  logic [0:ADDR_W-1]   ex_addr,
    input  logic [0:DATA_W-1]   ex_data,
    input  logic                wb_wr_en,
    input  logic [0:ADDR_W-1]   wb_addr,
    input  logic [0:DATA_W-1]   wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [0:DATA_W-1]   rA_64bit_val,
    output logic [0:DATA_W-1]   rB_64bit_val,
    output logic [0:5]          Op_code,
    output logic [0:5]          R_ins,
    output logic [0:1]          WW,
    output logic [0:ADDR_W-1]   rD_addr,
    output logic                out_wr_en
);

    localparam logic [0:5] OP_VECTOR = 6'b101010;

    logic [0:5]        opField;
    logic [0:ADDR_W-1] rdField;
    logic [0:ADDR_W-1] raField;
    logic [0:ADDR_W-1] rbField;
    logic [0:1]        wwField;
    logic [0:5]        funcField;
    logic              unusedInstrBits;
    logic              rbUsed;
    logic              hazard;
    logic              capture;
    logic [0:DATA_W-1] opSelA;
    logic [0:DATA_W-1] opSelB;

    logic              valid_q, valid_d;
    logic [0:DATA_W-1] opA_q, opA_d;
    logic [0:DATA_W-1] opB_q, opB_d;
    logic [0:5]        opcode_q, opcode_d;
    logic [0:5]        func_q, func_d;
    logic [0:1]        ww_q, ww_d;
    logic [0:ADDR_W-1] rd_q, rd_d;
    logic              wrEn_q, wrEn_d;

    assign opField         = in_instr[0:5];
    assign rdField         = in_instr[6:10];
    assign raField         = in_instr[11:15];
    assign rbField         = in_instr[16:20];
    assign wwField         = in_instr[24:25];
    assign funcField       = in_instr[26:31];
    assign unusedInstrBits = ^in_instr[21:23];

    // Single-source vector ops (VNOT, VMOV, VRTTH, VSQEU, VSQOU, VSQRT) never read rB.
    always_comb begin
        rbUsed = 1'b1;
        if (opField == OP_VECTOR) begin
            case (funcField)
                6'b000100, 6'b000101, 6'b001101,
                6'b010000, 6'b010001, 6'b010010: rbUsed = 1'b0;
                default:                         rbUsed = 1'b1;
            endcase
        end
    end

`ifdef ALU_OPERAND_STAGE_FWD_EN
    always_comb begin
        hazard = ex_pending && ((ex_addr == raField) || (rbUsed && (ex_addr == rbField)));
    end

    // EX is younger than WB, so its result wins when both target the same register.
    always_comb begin
        opSelA = in_rA_data;
        opSelB = in_rB_data;
        if (wb_wr_en && (wb_addr == raField))      opSelA = wb_data;
        if (ex_fwd_valid && (ex_addr == raField))  opSelA = ex_data;
        if (wb_wr_en && (wb_addr == rbField))      opSelB = wb_data;
        if (ex_fwd_valid && (ex_addr == rbField))  opSelB = ex_data;
    end
`else
    logic exBusy;
    logic unusedFwdData;

    assign exBusy        = ex_pending || ex_fwd_valid;
    assign unusedFwdData = ^{ex_data, wb_data};

    // Without bypass paths the value is only usable once the register file has absorbed the WB write.
    always_comb begin
        hazard = (exBusy && (ex_addr == raField))
              || (exBusy && rbUsed && (ex_addr == rbField))
              || (wb_wr_en && (wb_addr == raField))
              || (wb_wr_en && rbUsed && (wb_addr == rbField));
    end

    always_comb begin
        opSelA = in_rA_data;
        opSelB = in_rB_data;
    end
`endif

    assign in_ready = (~valid_q | out_ready) & ~hazard & ~flush;
    assign capture  = in_valid & in_ready;

    // Flush dominates; a held entry is never re-snooped, only replaced on capture.
    always_comb begin
        valid_d  = valid_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        opcode_d = opcode_q;
        func_d   = func_q;
        ww_d     = ww_q;
        rd_d     = rd_q;
        wrEn_d   = wrEn_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            opA_d    = opSelA;
            opB_d    = opSelB;
            opcode_d = opField;
            func_d   = funcField;
            ww_d     = wwField;
            rd_d     = rdField;
            wrEn_d   = (opField == OP_VECTOR);
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            opA_q    <= '0;
            opB_q    <= '0;
            opcode_q <= '0;
            func_q   <= '0;
            ww_q     <= '0;
            rd_q     <= '0;
            wrEn_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            opcode_q <= opcode_d;
            func_q   <= func_d;
            ww_q     <= ww_d;
            rd_q     <= rd_d;
            wrEn_q   <= wrEn_d;
        end
    end

    assign out_valid    = valid_q;
    assign rA_64bit_val = opA_q;
    assign rB_64bit_val = opB_q;
    assign Op_code      = opcode_q;
    assign R_ins        = func_q;
    assign WW           = ww_q;
    assign rD_addr      = rd_q;
    assign out_wr_en    = wrEn_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a driver predicts acceptance and operand values from
// architectural rules, a negedge monitor compares whatever the stage presents to the ALU.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] in_instr;
    logic [0:63] in_rA_data;
    logic [0:63] in_rB_data;
    logic        ex_fwd_valid;
    logic        ex_pending;
    logic [0:4]  ex_addr;
    logic [0:63] ex_data;
    logic        wb_wr_en;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [0:63] rA_64bit_val;
    logic [0:63] rB_64bit_val;
    logic [0:5]  Op_code;
    logic [0:5]  R_ins;
    logic [0:1]  WW;
    logic [0:4]  rD_addr;
    logic        out_wr_en;

    typedef struct {
        logic [63:0] opA;
        logic [63:0] opB;
        logic [5:0]  opcode;
        logic [5:0]  func;
        logic [1:0]  ww;
        logic [4:0]  rd;
        logic        wrEn;
    } expT;

    expT         sbQ[$];
    logic [63:0] rf[32];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rA_data(in_rA_data), .in_rB_data(in_rB_data),
        .ex_fwd_valid(ex_fwd_valid), .ex_pending(ex_pending), .ex_addr(ex_addr), .ex_data(ex_data),
        .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rA_64bit_val(rA_64bit_val), .rB_64bit_val(rB_64bit_val),
        .Op_code(Op_code), .R_ins(R_ins), .WW(WW), .rD_addr(rD_addr), .out_wr_en(out_wr_en)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit readsRb(input logic [5:0] op, input logic [5:0] fn);
        return !(op == 6'b101010 && (fn inside {6'd4, 6'd5, 6'd13, 6'd16, 6'd17, 6'd18}));
    endfunction

    // A register is unavailable while a write to it is still outstanding somewhere the stage cannot see.
    function automatic bit notYetAvailable(input logic [4:0] addr);
`ifdef ALU_OPERAND_STAGE_FWD_EN
        return ex_pending && (ex_addr == addr);
`else
        return ((ex_pending || ex_fwd_valid) && ex_addr == addr) || (wb_wr_en && wb_addr == addr);
`endif
    endfunction

    function automatic logic [63:0] newestValue(input logic [4:0] addr);
`ifdef ALU_OPERAND_STAGE_FWD_EN
        if (ex_fwd_valid && ex_addr == addr) return ex_data;
        if (wb_wr_en && wb_addr == addr)     return wb_data;
`endif
        return rf[addr];
    endfunction

    // Drives one cycle of inputs shortly after a rising edge and predicts whether the stage accepts it.
    task automatic applyStimulus(
        input logic vld, input logic [5:0] op, input logic [4:0] rd, input logic [4:0] ra,
        input logic [4:0] rb, input logic [1:0] ww, input logic [5:0] fn,
        input logic exFwd, input logic exPend, input logic [4:0] exA, input logic [63:0] exD,
        input logic wbEn, input logic [4:0] wbA, input logic [63:0] wbD,
        input logic outRdy, input logic doFlush);
        bit   hazard;
        bit   expReady;
        bit   take;
        expT  e;
        in_valid     = vld;
        in_instr     = {op, rd, ra, rb, 3'b000, ww, fn};
        in_rA_data   = rf[ra];
        in_rB_data   = rf[rb];
        ex_fwd_valid = exFwd;
        ex_pending   = exPend;
        ex_addr      = exA;
        ex_data      = exD;
        wb_wr_en     = wbEn;
        wb_addr      = wbA;
        wb_data      = wbD;
        out_ready    = outRdy;
        flush        = doFlush;
        hazard   = notYetAvailable(ra) || (readsRb(op, fn) && notYetAvailable(rb));
        expReady = ((sbQ.size() == 0) || outRdy) && !hazard && !doFlush;
        #1;
        checkOutput("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        take     = vld && expReady;
        e.opA    = newestValue(ra);
        e.opB    = newestValue(rb);
        e.opcode = op;
        e.func   = fn;
        e.ww     = ww;
        e.rd     = rd;
        e.wrEn   = (op == 6'b101010);
        @(posedge clk);
        if (wbEn) rf[wbA] = wbD;
        if (take) sbQ.push_back(e);
        #2;
    endtask

    always @(negedge clk) begin
        assert (!(ex_fwd_valid && ex_pending)) else $error("[TB] illegal ex_fwd_valid with ex_pending");
    end

    // Monitor: the stage holds at most one entry, presented until consumed or squashed.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("out_valid", {63'd0, out_valid}, {63'd0, sbQ.size() != 0});
            if (out_valid && sbQ.size() != 0) begin
                checkOutput("rA_64bit_val", rA_64bit_val, sbQ[0].opA);
                checkOutput("rB_64bit_val", rB_64bit_val, sbQ[0].opB);
                checkOutput("Op_code", {58'd0, Op_code}, {58'd0, sbQ[0].opcode});
                checkOutput("R_ins", {58'd0, R_ins}, {58'd0, sbQ[0].func});
                checkOutput("WW", {62'd0, WW}, {62'd0, sbQ[0].ww});
                checkOutput("rD_addr", {59'd0, rD_addr}, {59'd0, sbQ[0].rd});
                checkOutput("out_wr_en", {63'd0, out_wr_en}, {63'd0, sbQ[0].wrEn});
                if (out_ready || flush) void'(sbQ.pop_front());
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " out_valid"}, {63'd0, out_valid}, 64'd0);
        checkOutput({tag, " rA_64bit_val"}, rA_64bit_val, 64'd0);
        checkOutput({tag, " rB_64bit_val"}, rB_64bit_val, 64'd0);
        checkOutput({tag, " ctrl"}, {44'd0, Op_code, R_ins, WW, rD_addr, out_wr_en}, 64'd0);
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] exA;
        int         exMode;
        logic [5:0] fnList[8] = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd13, 6'd16, 6'd17, 6'd18};

        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[1] = 64'd5;
        rf[2] = 64'd10;
        rf[4] = 64'd44;
        reset = 1'b1;
        in_valid = 0; in_instr = '0; in_rA_data = '0; in_rB_data = '0;
        ex_fwd_valid = 0; ex_pending = 0; ex_addr = '0; ex_data = '0;
        wb_wr_en = 0; wb_addr = '0; wb_data = '0; flush = 0; out_ready = 0;
        #3;
        checkAllZero("reset");
        checkOutput("reset in_ready", {63'd0, in_ready}, 64'd1);
        #4 reset = 1'b0;
        @(posedge clk);
        #2;

        // Single issue, then EX-over-WB priority.
        applyStimulus(1, 6'b101010, 3, 1, 2, 2'b10, 6'b000110, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 6'b101010, 3, 1, 2, 2'b10, 6'b000110, 1, 0, 1, 64'hFFFFFFFF_00000000, 1, 1, 64'd7, 1, 0);
        applyStimulus(1, 6'b101010, 3, 1, 2, 2'b10, 6'b000110, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Load-use stall on rB, then the result arrives.
        applyStimulus(1, 6'b101010, 5, 1, 2, 2'b01, 6'b000111, 0, 1, 2, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 6'b101010, 5, 1, 2, 2'b01, 6'b000111, 0, 1, 2, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 6'b101010, 5, 1, 2, 2'b01, 6'b000111, 1, 0, 2, 64'd14, 0, 0, 0, 1, 0);
        applyStimulus(1, 6'b101010, 5, 1, 2, 2'b01, 6'b000111, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // VMOV ignores a pending rB.
        applyStimulus(1, 6'b101010, 6, 4, 2, 2'b00, 6'b000101, 0, 1, 2, 0, 0, 0, 0, 1, 0);
        // Backpressure for three cycles, then a flush squashes the held entry.
        applyStimulus(1, 6'b101010, 7, 1, 4, 2'b11, 6'b000001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 6'b000011, 8, 2, 4, 2'b00, 6'b000010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 6'b000011, 8, 2, 4, 2'b00, 6'b000010, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 6'b000000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        for (int n = 0; n < 1500; n++) begin
            op  = ($urandom_range(0, 9) < 6) ? 6'b101010 : 6'($urandom_range(0, 63));
            fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fnList[$urandom_range(0, 7)];
            ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            rb  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            exA = 5'($urandom_range(0, 3));
            exMode = $urandom_range(0, 9);
            applyStimulus($urandom_range(0, 9) < 8, op, 5'($urandom_range(0, 31)), ra, rb,
                          2'($urandom_range(0, 3)), fn,
                          exMode >= 3 && exMode <= 5, exMode <= 2, exA, {$urandom, $urandom},
                          $urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), {$urandom, $urandom},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        // Fill the stage, hold it, then pulse reset between edges.
        applyStimulus(0, 6'b000000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 6'b101010, 9, 1, 2, 2'b10, 6'b000110, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 6'b000000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hold out_valid", {63'd0, out_valid}, 64'd1);
        #1 reset = 1'b1;
        sbQ.delete();
        #1;
        checkAllZero("async reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #2;
        applyStimulus(0, 6'b000000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
